instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Producer side of the instruction-word interface. Holds the program counter and fetches the 32-bit instruction from instruction memory over a req/ack handshake.
- Presents the word to the instruction decoder with a valid flag.
- After the CPU signals that execution is complete, consumes the decoder's Branch/Jump/JumpReg/InvZero flags plus the ALU Zero and register Da to select the next PC.
- Sits between instruction memory and the decoder and datapath of the single-cycle CPU.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; equals pc.
- imem_ack  input  1  memory has imem_data valid this cycle.
- imem_data  input  32  fetched instruction word.
- instruction  output  32  registered instruction word to the decoder.
- instr_valid  output  1  instruction holds the word fetched from pc.
- exec_done  input  1  CPU finished the current instruction; flags below are valid this cycle.
- Branch  input  1  decoder: conditional branch.
- Jump  input  1  decoder: absolute jump (j/jal).
- JumpReg  input  1  decoder: jump to register (jr).
- InvZero  input  1  decoder: invert Zero (bne).
- Zero  input  1  ALU zero flag.
- Da  input  32  register-file read port A (jr target).
- pc  output  32  current program counter.
- pc_plus4  output  32  pc+4 mod 2^32, combinational; used as the jal link value.

Behaviour:
- States: REQ, ISSUE. The encoding lives in the shared package.
- Reset (reset_n=0 at a clock edge) forces:
  - state=REQ, pc=RESET_PC, instruction=0, instr_valid=0.
  - imem_req is driven 0 while reset_n=0.
  - Reset overrides any handshake in flight; an ack arriving in the reset cycle is discarded.
- REQ:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - imem_addr is held stable until ack.
  - On imem_ack=1: register imem_data into instruction, set instr_valid=1 next cycle, go to ISSUE.
  - Without ack, stay in REQ indefinitely. No timeout.
- ISSUE:
  - imem_req=0, instr_valid=1, instruction and pc held.
  - imem_ack in this state is ignored.
  - On exec_done=1: load pc with next_pc, set instr_valid=0, go to REQ.
  - exec_done seen while in REQ is ignored.
- next_pc priority (evaluated only in the ISSUE cycle where exec_done=1):
  1. JumpReg: {Da[31:2],2'b00}. Misaligned low bits are dropped.
  2. Jump: {pc_plus4[31:28], instruction[25:0], 2'b00}.
  3. Branch & (Zero ^ InvZero): pc_plus4 + {{14{instruction[15]}}, instruction[15:0], 2'b00}, mod 2^32.
  4. Otherwise pc_plus4.
- Width rules:
  - All PC arithmetic is 32-bit unsigned with wrap-around (pc=FFFF_FFFC -> next 0000_0000).
  - Branch offset is sign-extended; negative offsets wrap correctly.
- Timing:
  - Minimum throughput is 2 cycles per instruction: ack in REQ, then exec_done in the first ISSUE cycle.
  - Latency from ack to instr_valid is 1 cycle.
- Multiple flags set simultaneously resolve by the priority above. This is not an error.

Decomposition:
- Shared package: state encoding constants (FETCH_REQ, FETCH_ISSUE) and the default reset PC constant.
- One combinational sub-module, next_pc_calc. Inputs: pc_plus4, instruction, Da, Branch, Jump, JumpReg, InvZero, Zero. Output: next_pc. It is unit-tested independently.
- The FSM and registers stay in the top.

Test Plan:
- Reset then sequential fetch: reset_n low 2 cycles, memory acks every REQ after 0 wait, exec_done the next cycle, no flags. Required:
  - imem_addr sequence 0,4,8,C.
  - instr_valid one cycle after each ack.
- Wait states: ack delayed 3 cycles with address 0x10. Required:
  - imem_req stays 1 and imem_addr=0x10 for 4 cycles.
  - instr_valid rises exactly 1 cycle after ack.
- Branch: pc=0x20, instruction imm=0xFFFE, Branch=1.
  - Zero=1 -> pc=0x1C.
  - Zero=1 with InvZero=1 -> pc=0x24.
- Jumps:
  - pc=0x40, instruction[25:0]=0x0000100, Jump=1 -> pc=0x400.
  - JumpReg=1 with Da=0x1237 (JumpReg and Jump both set) -> pc=0x1234.
- Wrap: pc=FFFF_FFFC, no flags -> pc=0, pc_plus4 shown as 0 before exec_done.
- Reset mid-operation: reset_n low while in REQ with ack arriving that same cycle. Required:
  - instruction=0, instr_valid=0, pc=RESET_PC.
  - Next fetch address is RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_pkg
// Shared definitions for the instruction fetch unit and its helpers.
//   fetchState_t      : two-state fetch sequencer encoding (FETCH_REQ, FETCH_ISSUE)
//   DEFAULT_RESET_PC  : program counter value used after reset
// ---------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

   // FETCH_REQ waits on instruction memory, FETCH_ISSUE holds the word
   // in front of the decoder until the CPU reports completion.
   typedef enum logic {
      FETCH_REQ   = 1'b0,
      FETCH_ISSUE = 1'b1
   } fetchState_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_unit_next_pc_calc.sv
// ---------------------------------------------------------------------------
// next_pc_calc
// Purely combinational next program counter selection.
// Ports:
//   pc_plus4    in  32  sequential successor of the current pc
//   instruction in  32  instruction word being executed
//   Da          in  32  register-file read port A (jr target)
//   Branch      in   1  conditional branch
//   Jump        in   1  absolute jump (j/jal)
//   JumpReg     in   1  jump to register (jr)
//   InvZero     in   1  invert the Zero condition (bne)
//   Zero        in   1  ALU zero flag
//   next_pc     out 32  selected next program counter
// ---------------------------------------------------------------------------
module next_pc_calc
   import instruction_fetch_unit_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [31:0] instruction,
   input  logic [31:0] Da,
   input  logic        Branch,
   input  logic        Jump,
   input  logic        JumpReg,
   input  logic        InvZero,
   input  logic        Zero,
   output logic [31:0] next_pc
);

   logic [31:0] branchOffset;
   logic [31:0] branchTarget;
   logic [31:0] jumpTarget;
   logic [31:0] regTarget;
   logic        branchTaken;

   // The opcode field and the low two bits of the register target never
   // influence the result; they are gathered here so the intent is explicit.
   logic unusedBits;
   assign unusedBits = &{1'b0, Da[1:0], instruction[31:26]};

   // Candidate targets. The branch offset is a signed word count, so it is
   // sign-extended and shifted to a byte offset; the addition wraps mod 2^32.
   // A register target is forced word-aligned by discarding its low bits.
   always_comb begin
      branchOffset = {{14{instruction[15]}}, instruction[15:0], 2'b00};
      branchTarget = pc_plus4 + branchOffset;
      jumpTarget   = {pc_plus4[31:28], instruction[25:0], 2'b00};
      regTarget    = {Da[31:2], 2'b00};
      branchTaken  = Branch & (Zero ^ InvZero);
   end

   // Priority select: jr beats j, j beats a taken branch, otherwise fall
   // through. Several flags at once are legal and simply resolve here.
   always_comb begin
      next_pc = pc_plus4;
      if (JumpReg) begin
         next_pc = regTarget;
      end else if (Jump) begin
         next_pc = jumpTarget;
      end else if (branchTaken) begin
         next_pc = branchTarget;
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Holds the program counter, fetches instruction words over a req/ack
// handshake and presents them to the decoder until execution completes.
// Ports:
//   clk          in   1  system clock, rising edge active
//   reset_n      in   1  synchronous active-low reset
//   imem_req     out  1  fetch request to instruction memory
//   imem_addr    out 32  fetch address (always equals pc)
//   imem_ack     in   1  imem_data is valid this cycle
//   imem_data    in  32  fetched instruction word
//   instruction  out 32  registered instruction word to the decoder
//   instr_valid  out  1  instruction holds the word fetched from pc
//   exec_done    in   1  CPU finished the current instruction
//   Branch/Jump/JumpReg/InvZero in 1 each  decoder control flags
//   Zero         in   1  ALU zero flag
//   Da           in  32  register-file read port A
//   pc           out 32  current program counter
//   pc_plus4     out 32  pc + 4 (jal link value), combinational
// ---------------------------------------------------------------------------
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   output logic [31:0] instruction,
   output logic        instr_valid,
   input  logic        exec_done,
   input  logic        Branch,
   input  logic        Jump,
   input  logic        JumpReg,
   input  logic        InvZero,
   input  logic        Zero,
   input  logic [31:0] Da,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
);

   fetchState_t fetchState;
   logic [31:0] nextPc;

   // The sequential successor doubles as the jal link value and as the
   // base for branch targets; 32-bit addition wraps naturally.
   assign pc_plus4  = pc + 32'd4;
   assign imem_addr = pc;

   // Request is gated with reset so memory never sees a request while the
   // unit is being reset, even though the state register only updates on
   // the clock edge.
   assign imem_req = reset_n & (fetchState == FETCH_REQ);

   next_pc_calc nextPcCalc (
      .pc_plus4    (pc_plus4),
      .instruction (instruction),
      .Da          (Da),
      .Branch      (Branch),
      .Jump        (Jump),
      .JumpReg     (JumpReg),
      .InvZero     (InvZero),
      .Zero        (Zero),
      .next_pc     (nextPc)
   );

   // Fetch sequencer. In FETCH_REQ the pc is held as the fetch address until
   // memory acknowledges; the word is captured and flagged valid. In
   // FETCH_ISSUE the word and pc stay frozen until the CPU signals completion,
   // at which point the pc advances to the selected target. Acks seen in
   // FETCH_ISSUE and completions seen in FETCH_REQ are ignored. Reset wins
   // over everything, including an ack arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fetchState  <= FETCH_REQ;
         pc          <= RESET_PC;
         instruction <= 32'h0000_0000;
         instr_valid <= 1'b0;
      end else begin
         case (fetchState)
            FETCH_REQ: begin
               if (imem_ack) begin
                  instruction <= imem_data;
                  instr_valid <= 1'b1;
                  fetchState  <= FETCH_ISSUE;
               end
            end
            FETCH_ISSUE: begin
               if (exec_done) begin
                  pc          <= nextPc;
                  instr_valid <= 1'b0;
                  fetchState  <= FETCH_REQ;
               end
            end
            default: begin
               fetchState  <= FETCH_REQ;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Self-checking bench for instruction_fetch_unit. Keeps its own model of the
// program counter computed from the next-pc rules with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        reset_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic [31:0] instruction;
   logic        instr_valid;
   logic        exec_done;
   logic        Branch;
   logic        Jump;
   logic        JumpReg;
   logic        InvZero;
   logic        Zero;
   logic [31:0] Da;
   logic [31:0] pc;
   logic [31:0] pc_plus4;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] expPc;
   logic [31:0] lastWord;

   instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .exec_done   (exec_done),
      .Branch      (Branch),
      .Jump        (Jump),
      .JumpReg     (JumpReg),
      .InvZero     (InvZero),
      .Zero        (Zero),
      .Da          (Da),
      .pc          (pc),
      .pc_plus4    (pc_plus4)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model of the next program counter, written from the
   // architectural rules with ordinary integer arithmetic.
   function automatic logic [31:0] modelNextPc(input logic [31:0] curPc, input logic [31:0] word,
                                               input logic [31:0] da, input logic br, input logic j,
                                               input logic jr, input logic inv, input logic z);
      logic [31:0] seq;
      int          off;
      seq = curPc + 32'd4;
      if (jr) return da - (da % 32'd4);
      if (j) return (seq & 32'hF000_0000) + (word % 32'h0400_0000) * 32'd4;
      if (br && (z != inv)) begin
         off = int'($signed(word[15:0]));
         return seq + 32'(off * 4);
      end
      return seq;
   endfunction

   // Memory answers the pending request in the current cycle.
   task automatic ackWord(input logic [31:0] word);
      imem_ack  = 1'b1;
      imem_data = word;
      lastWord  = word;
      @(negedge clk);
      imem_ack  = 1'b0;
      imem_data = $urandom();
   endtask

   // CPU signals completion with the given flags; a stray ack is thrown in
   // at random since the unit must ignore it while issuing.
   task automatic applyStimulus(input logic br, input logic j, input logic jr,
                                input logic inv, input logic z, input logic [31:0] da);
      exec_done = 1'b1;
      Branch    = br;
      Jump      = j;
      JumpReg   = jr;
      InvZero   = inv;
      Zero      = z;
      Da        = da;
      imem_ack  = 1'($urandom_range(0, 1));
      imem_data = $urandom();
      expPc     = modelNextPc(expPc, lastWord, da, br, j, jr, inv, z);
      @(negedge clk);
      exec_done = 1'b0;
      Branch    = 1'b0;
      Jump      = 1'b0;
      JumpReg   = 1'b0;
      InvZero   = 1'b0;
      Zero      = 1'b0;
      imem_ack  = 1'b0;
      Da        = $urandom();
   endtask

   task automatic jumpTo(input logic [31:0] target);
      ackWord($urandom());
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, target);
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b exp 0", imem_req); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", instr_valid); end
      checks++; if (instruction !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr got %h exp 0", instruction); end
      checks++; if (pc !== RESET_PC) begin errors++; $display("[TB] FAIL reset_pc got %h exp %h", pc, RESET_PC); end
      reset_n = 1'b1;
      expPc   = RESET_PC;
      #1;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_after got %b exp 1", imem_req); end
      checks++; if (imem_addr !== RESET_PC) begin errors++; $display("[TB] FAIL reset_addr got %h exp %h", imem_addr, RESET_PC); end
   endtask

   task automatic test_sequential;
      logic [31:0] word;
      for (int i = 0; i < 4; i++) begin
         checks++; if (imem_addr !== 32'(i * 4)) begin errors++; $display("[TB] FAIL seq_addr got %h exp %h", imem_addr, 32'(i * 4)); end
         checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL seq_req got %b exp 1", imem_req); end
         checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_valid_pre got %b exp 0", instr_valid); end
         word = $urandom();
         ackWord(word);
         checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid got %b exp 1", instr_valid); end
         checks++; if (instruction !== word) begin errors++; $display("[TB] FAIL seq_instr got %h exp %h", instruction, word); end
         checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL seq_req_issue got %b exp 0", imem_req); end
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom());
      end
   endtask

   task automatic test_wait_states;
      logic [31:0] word;
      for (int c = 0; c < 4; c++) begin
         checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL wait_req got %b exp 1", imem_req); end
         checks++; if (imem_addr !== 32'h10) begin errors++; $display("[TB] FAIL wait_addr got %h exp 00000010", imem_addr); end
         checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL wait_valid got %b exp 0", instr_valid); end
         if (c == 1) begin
            exec_done = 1'b1;
            JumpReg   = 1'b1;
            Da        = 32'h0000_0080;
         end
         if (c < 3) begin
            @(negedge clk);
            exec_done = 1'b0;
            JumpReg   = 1'b0;
         end
      end
      word = $urandom();
      ackWord(word);
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL wait_valid_after got %b exp 1", instr_valid); end
      checks++; if (instruction !== word) begin errors++; $display("[TB] FAIL wait_instr got %h exp %h", instruction, word); end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom());
      checks++; if (pc !== 32'h14) begin errors++; $display("[TB] FAIL wait_next_pc got %h exp 00000014", pc); end
   endtask

   task automatic test_branch;
      jumpTo(32'h20);
      checks++; if (pc !== 32'h20) begin errors++; $display("[TB] FAIL br_setup got %h exp 00000020", pc); end
      ackWord(32'h1000_FFFE);
      checks++; if (pc_plus4 !== 32'h24) begin errors++; $display("[TB] FAIL br_plus4 got %h exp 00000024", pc_plus4); end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, $urandom());
      checks++; if (pc !== 32'h1C) begin errors++; $display("[TB] FAIL br_taken got %h exp 0000001c", pc); end
      jumpTo(32'h20);
      ackWord(32'h1400_FFFE);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, $urandom());
      checks++; if (pc !== 32'h24) begin errors++; $display("[TB] FAIL br_inv got %h exp 00000024", pc); end
   endtask

   task automatic test_jumps;
      jumpTo(32'h40);
      ackWord(32'h0800_0100);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $urandom());
      checks++; if (pc !== 32'h400) begin errors++; $display("[TB] FAIL jump got %h exp 00000400", pc); end
      ackWord(32'h0800_0200);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1237);
      checks++; if (pc !== 32'h1234) begin errors++; $display("[TB] FAIL jumpreg got %h exp 00001234", pc); end
   endtask

   task automatic test_wrap;
      jumpTo(32'hFFFF_FFFC);
      checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_addr got %h exp fffffffc", imem_addr); end
      ackWord($urandom());
      checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("[TB] FAIL wrap_plus4 got %h exp 00000000", pc_plus4); end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom());
      checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc got %h exp 00000000", pc); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] word;
      jumpTo(32'h300);
      checks++; if (imem_addr !== 32'h300) begin errors++; $display("[TB] FAIL rmid_setup got %h exp 00000300", imem_addr); end
      reset_n   = 1'b0;
      imem_ack  = 1'b1;
      imem_data = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_ack  = 1'b0;
      checks++; if (instruction !== 32'h0) begin errors++; $display("[TB] FAIL rmid_instr got %h exp 00000000", instruction); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_valid got %b exp 0", instr_valid); end
      checks++; if (pc !== RESET_PC) begin errors++; $display("[TB] FAIL rmid_pc got %h exp %h", pc, RESET_PC); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rmid_req got %b exp 0", imem_req); end
      reset_n = 1'b1;
      expPc   = RESET_PC;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rmid_req_after got %b exp 1", imem_req); end
      checks++; if (imem_addr !== RESET_PC) begin errors++; $display("[TB] FAIL rmid_addr got %h exp %h", imem_addr, RESET_PC); end
      word = $urandom();
      ackWord(word);
      checks++; if (instruction !== word) begin errors++; $display("[TB] FAIL rmid_fetch got %h exp %h", instruction, word); end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom());
      checks++; if (pc !== RESET_PC + 32'd4) begin errors++; $display("[TB] FAIL rmid_next got %h exp %h", pc, RESET_PC + 32'd4); end
   endtask

   task automatic test_random;
      logic [31:0] word;
      logic        br, j, jr, inv, z;
      for (int n = 0; n < 60; n++) begin
         for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
            checks++; if (imem_addr !== expPc) begin errors++; $display("[TB] FAIL rnd_wait_addr got %h exp %h", imem_addr, expPc); end
            @(negedge clk);
         end
         checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rnd_req got %b exp 1", imem_req); end
         word = $urandom();
         ackWord(word);
         for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
            @(negedge clk);
         end
         checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL rnd_valid got %b exp 1", instr_valid); end
         checks++; if (instruction !== word) begin errors++; $display("[TB] FAIL rnd_instr got %h exp %h", instruction, word); end
         checks++; if (pc_plus4 !== expPc + 32'd4) begin errors++; $display("[TB] FAIL rnd_plus4 got %h exp %h", pc_plus4, expPc + 32'd4); end
         jr  = ($urandom_range(0, 5) == 0);
         j   = ($urandom_range(0, 4) == 0);
         br  = 1'($urandom_range(0, 1));
         inv = 1'($urandom_range(0, 1));
         z   = 1'($urandom_range(0, 1));
         applyStimulus(br, j, jr, inv, z, $urandom());
         checks++; if (pc !== expPc) begin errors++; $display("[TB] FAIL rnd_pc got %h exp %h", pc, expPc); end
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      imem_ack  = 1'b0;
      imem_data = 32'h0;
      exec_done = 1'b0;
      Branch    = 1'b0;
      Jump      = 1'b0;
      JumpReg   = 1'b0;
      InvZero   = 1'b0;
      Zero      = 1'b0;
      Da        = 32'h0;
      expPc     = RESET_PC;
      lastWord  = 32'h0;
      test_reset();
      test_sequential();
      test_wait_states();
      test_branch();
      test_jumps();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
